// File: rtl/layer_sequencer.sv
// Drives a spiking layer through a train-then-test run, streaming in spike-time
// images and streaming out one indexed winner per testing image.
module layer_sequencer #(
  parameter int TIME_PERIOD    = 16,
  parameter int TESTING_PERIOD = 8,
  parameter int NUM_SPIKES     = 4,
  parameter int SPIKE_W        = 4,
  parameter int TIME_W         = 5,
  parameter int NEURON_W       = 3
) (
  input  logic                          clk,
  input  logic                          rst_l,
  input  logic                          start,
  input  logic [15:0]                   num_train,
  input  logic [15:0]                   num_test,
  input  logic                          img_valid,
  output logic                          img_ready,
  input  logic [NUM_SPIKES*SPIKE_W-1:0] img_spikes,
  output logic [NUM_SPIKES*SPIKE_W-1:0] layer_spike_times,
  output logic [TIME_W-1:0]             layer_time_val,
  output logic                          layer_training,
  input  logic [NEURON_W-1:0]           winning_neuron,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [NEURON_W-1:0]           res_neuron,
  output logic [15:0]                   res_index,
  output logic                          busy,
  output logic                          done
);

  typedef enum logic [2:0] {IDLE, LOAD, TRAIN_RUN, TEST_RUN, RESULT, DONE} state_t;

  localparam logic [TIME_W-1:0] TRAIN_LAST = TIME_W'(TIME_PERIOD - 1);
  localparam logic [TIME_W-1:0] TEST_LAST  = TIME_W'(TESTING_PERIOD - 1);

  state_t      state;
  logic        phase_test;
  logic [15:0] cnt;
  logic [15:0] train_total;
  logic [15:0] test_total;

  // Every output is written alongside the state transition that implies it,
  // so img_ready/res_valid never depend combinationally on img_valid/res_ready.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state             <= IDLE;
      phase_test        <= 1'b0;
      cnt               <= '0;
      train_total       <= '0;
      test_total        <= '0;
      img_ready         <= 1'b0;
      res_valid         <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      layer_training    <= 1'b0;
      layer_time_val    <= '0;
      layer_spike_times <= '0;
      res_neuron        <= '0;
      res_index         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            train_total <= num_train;
            test_total  <= num_test;
            cnt         <= '0;
            busy        <= 1'b1;
            if (num_train != 16'd0) begin
              state          <= LOAD;
              phase_test     <= 1'b0;
              img_ready      <= 1'b1;
              layer_training <= 1'b1;
            end else if (num_test != 16'd0) begin
              state          <= LOAD;
              phase_test     <= 1'b1;
              img_ready      <= 1'b1;
              layer_training <= 1'b0;
            end else begin
              state          <= DONE;
              phase_test     <= 1'b1;
              done           <= 1'b1;
              layer_training <= 1'b0;
            end
          end
        end
        LOAD: begin
          if (img_valid) begin
            layer_spike_times <= img_spikes;
            layer_time_val    <= '0;
            img_ready         <= 1'b0;
            state             <= phase_test ? TEST_RUN : TRAIN_RUN;
          end
        end
        TRAIN_RUN: begin
          if (layer_time_val == TRAIN_LAST) begin
            layer_time_val <= '0;
            if (cnt + 16'd1 == train_total) begin
              phase_test     <= 1'b1;
              layer_training <= 1'b0;
              cnt            <= '0;
              if (test_total != 16'd0) begin
                state     <= LOAD;
                img_ready <= 1'b1;
              end else begin
                state <= DONE;
                done  <= 1'b1;
              end
            end else begin
              cnt       <= cnt + 16'd1;
              state     <= LOAD;
              img_ready <= 1'b1;
            end
          end else begin
            layer_time_val <= layer_time_val + TIME_W'(1);
          end
        end
        TEST_RUN: begin
          if (layer_time_val == TEST_LAST) begin
            res_neuron     <= winning_neuron;
            res_index      <= cnt;
            res_valid      <= 1'b1;
            layer_time_val <= '0;
            state          <= RESULT;
          end else begin
            layer_time_val <= layer_time_val + TIME_W'(1);
          end
        end
        RESULT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            cnt       <= cnt + 16'd1;
            if (cnt + 16'd1 == test_total) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state     <= LOAD;
              img_ready <= 1'b1;
            end
          end
        end
        DONE: begin
          done           <= 1'b0;
          busy           <= 1'b0;
          layer_training <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/layer_sequencer.md
# layer_sequencer

Hardware controller that drives a spiking `layer` instance through a complete train-then-test run, replacing bench-driven sequencing.
- Accepts per-image spike-time vectors over a valid/ready stream.
- Generates the layer's `time_val` and `training` inputs.
- Holds `spike_times` stable for each image window.
- Captures `winning_neuron` at the end of every testing window and emits it as an indexed result over a second valid/ready stream.

## Interface
Parameters:
- `TIME_PERIOD`, 16: cycles per training image window.
- `TESTING_PERIOD`, 8: cycles per testing image window; must satisfy `TESTING_PERIOD <= TIME_PERIOD`.
- `NUM_SPIKES`, 4: input spike channels per image.
- `SPIKE_W`, 4: bits per spike time.
- `TIME_W`, 5: width of `time_val`; must hold `TIME_PERIOD-1`.
- `NEURON_W`, 3: width of `winning_neuron`.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_l`  in  1  synchronous, active-low reset.
- `start`  in  1  begin a run; sampled only in IDLE.
- `num_train`  in  16  training image count; latched on start.
- `num_test`  in  16  testing image count; latched on start.
- `img_valid`  in  1  image stream valid.
- `img_ready`  out  1  image stream ready.
- `img_spikes`  in  `NUM_SPIKES*SPIKE_W`  packed spike times; channel i occupies bits `[i*SPIKE_W +: SPIKE_W]`.
- `layer_spike_times`  out  `NUM_SPIKES*SPIKE_W`  registered copy of the accepted image.
- `layer_time_val`  out  `TIME_W`  layer time counter.
- `layer_training`  out  1  layer training enable.
- `winning_neuron`  in  `NEURON_W`  layer classification output.
- `res_valid`  out  1  result stream valid.
- `res_ready`  in  1  result stream ready.
- `res_neuron`  out  `NEURON_W`  captured winner.
- `res_index`  out  16  zero-based test image index of the result.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at end of run.

## Operation
States: IDLE, LOAD, TRAIN_RUN, TEST_RUN, RESULT, DONE. A `phase` bit (train/test) and a 16-bit image counter `cnt` are held internally.

- **IDLE:** `start=1` latches the counts and clears `cnt`.
  - `num_train>0`: go to LOAD with phase=train.
  - else `num_test>0`: go to LOAD with phase=test.
  - else: go to DONE.
  - `start` is ignored in every other state.
- **LOAD:** `img_ready=1`.
  - On `img_valid & img_ready`: register `img_spikes` into `layer_spike_times`, set `time_val` to 0, and go to TRAIN_RUN or TEST_RUN according to phase.
  - Without a handshake, stay in LOAD.
- **TRAIN_RUN:** `time_val` increments each cycle.
  - On the cycle with `time_val==TIME_PERIOD-1`, increment `cnt`.
  - If `cnt+1==num_train`: set phase=test, clear `cnt`, then go to LOAD if `num_test>0`, else DONE.
  - Otherwise return to LOAD.
- **TEST_RUN:** `time_val` increments each cycle.
  - On the cycle with `time_val==TESTING_PERIOD-1`: register `winning_neuron` into `res_neuron`, register `cnt` into `res_index`, and go to RESULT.
- **RESULT:** `res_valid=1`; `res_neuron` and `res_index` are held stable.
  - On `res_ready`: increment `cnt`; go to DONE if `cnt+1==num_test`, else LOAD.
- **DONE:** `done=1` for exactly one cycle, then IDLE.

Output rules:
- `layer_time_val` is 0 in every state other than TRAIN_RUN and TEST_RUN.
- `layer_training = (phase==train)` while `busy`, and 0 in IDLE.
- `layer_spike_times` changes only on an image handshake.

## Timing
- Reset values: state IDLE, `img_ready=0`, `res_valid=0`, `busy=0`, `done=0`, `layer_training=0`, `layer_time_val=0`, `layer_spike_times=0`, `res_neuron=0`, `res_index=0`, `cnt=0`, phase=train.
- `rst_l` low at any edge, including mid-run, forces all reset values on that edge; any in-flight image or result is discarded.
- Image handshake at cycle N: cycle N+1 shows `time_val=0` with the new spikes.
  - A training image occupies exactly `TIME_PERIOD` run cycles.
  - A testing image occupies exactly `TESTING_PERIOD` run cycles.
- Minimum LOAD residency is 1 cycle; no back-to-back windows without a LOAD cycle.
- `winning_neuron` is sampled on the final testing window cycle. `res_valid` rises on the next cycle.
- `img_ready` and `res_valid` are registered state decodes, with no combinational path from `img_valid` or `res_ready`.
- Phase switch: `layer_training` falls on the first cycle of test-phase LOAD.

## Test plan
- **Reset:** hold `rst_l=0` for 2 cycles with `start=1` → all outputs at reset values, state IDLE.
- **Single training image:** `start` at cycle 0, `num_train=1`, `num_test=0`, `img_valid` held high →
  - cycle 1 LOAD accepts the image;
  - cycles 2–17 show `time_val` 0..15 with `layer_training=1`;
  - cycle 18 `done=1`; cycle 19 IDLE.
- **Single testing image with result backpressure:** `num_train=0`, `num_test=1`, `winning_neuron=5` at `time_val=7`, `res_ready` low for 3 cycles →
  - `res_valid=1`, `res_neuron=5`, `res_index=0` held for 4 cycles with `time_val=0`;
  - `done` pulses the cycle after the handshake.
- **Full run:** `num_train=2`, `num_test=2` →
  - two 16-cycle windows with training=1, then training=0;
  - two 8-cycle windows with results at indices 0 and 1 carrying the sampled winners.
- **Image stream stalls:** `img_valid` low for 5 cycles in LOAD → `time_val` stays 0, `layer_spike_times` unchanged, `cnt` unchanged.
- **Control corner cases:**
  - `start` pulsed while busy → no effect.
  - `num_train=num_test=0` → DONE on the cycle after start.
  - `rst_l` low at `time_val=9` → IDLE with all reset values on the next edge.
